embertrail_dmem_responder: RTL and testbench
============================================

Name: embertrail_dmem_responder

Overview:
Data-memory responder on the memory side of the Embertrail data bus. It receives the core's data address, the per-bank read/write strobes and the per-bank bus enables, performs the access on one of two internal SRAM banks, and returns read data on the data bus with fixed wait states. It sits beside the core in the top level and replaces the external data memory model.

Parameters:
DEPTH, 256, words per bank (power of two)
WAIT_STATES, 1, extra cycles between request acceptance and response (0..7)

Ports:
iClock  in  1  single system clock, all logic on rising edge
iReset  in  1  synchronous, active-high reset
iDataAddrBus  in  32  byte address from core
iDataWrBus  in  32  write data from core
iDataMem1RW  in  1  bank 1 direction: 1=write, 0=read
iDataMem2RW  in  1  bank 2 direction: 1=write, 0=read
iData1BusEn  in  1  bank 1 request
iData2BusEn  in  1  bank 2 request
oDataDataBus  out  32  read data to core
oRdValid  out  1  one-cycle pulse, oDataDataBus valid
oWrDone  out  1  one-cycle pulse, write committed
oBusy  out  1  access in progress, new requests ignored
oErr  out  1  one-cycle pulse, request rejected or faulted

Behaviour:
- Reset: all outputs 0, FSM to IDLE, wait counter 0, captured request cleared. Bank contents NOT cleared. Reset mid-access aborts it: no write commit, no response pulse.
- FSM states: IDLE, WAIT, RESP.
- IDLE: request when exactly one of iData1BusEn/iData2BusEn is high. Capture address, write data, bank, and that bank's RW bit. Next state WAIT if WAIT_STATES>0 (counter loaded WAIT_STATES-1), else RESP.
- Both enables high in IDLE: oErr pulse next cycle, no access, remain IDLE.
- Address check at capture: iDataAddrBus[1:0]!=0 or word index >= DEPTH -> fault. Faulted request still passes through WAIT/RESP (fixed timing); in RESP oErr=1, write dropped, read returns 32'h0 with oRdValid=1.
- WAIT: counter decrements each cycle; at 0 go RESP.
- RESP (one cycle): read -> oDataDataBus = bank[word], oRdValid=1; write -> bank[word] written this edge, oWrDone=1. Next state IDLE.
- Latency: request sampled on edge N; response pulse high during cycle N+1+WAIT_STATES.
- oBusy=1 in WAIT and RESP. Request inputs ignored while oBusy; core holds/reissues. A request present in the cycle RESP ends is not accepted until the next IDLE cycle (one idle cycle minimum between accesses).
- oDataDataBus holds last read value until the next read response; unchanged by writes, errors from both-enable, or reset-free idle.
- Read-after-write same address: read sees new data (write commits before the next accept).
- Word index = iDataAddrBus[log2(DEPTH)+1:2]; upper bits must be zero.

Decomposition:
- Package embertrail_dmem_pkg: FSM state encoding (IDLE/WAIT/RESP), RW constants (RW_WRITE=1, RW_READ=0), bank-select encoding, error-read value 32'h0.
- Sub-module embertrail_dmem_bank: single-port synchronous RAM, DEPTH x 32, write enable, registered read; instantiated twice.

Test Plan:
- Reset then write bank1 addr 0x10 data 0xDEADBEEF, WAIT_STATES=1 -> oWrDone pulses 2 cycles after request, oBusy high 2 cycles, oErr=0.
- Read bank1 addr 0x10 -> oRdValid pulse at cycle N+2 with oDataDataBus=0xDEADBEEF; bank2 read of addr 0x10 returns bank2 contents, not 0xDEADBEEF.
- iData1BusEn=iData2BusEn=1 in IDLE -> oErr pulse next cycle, no oRdValid/oWrDone, oBusy stays 0.
- Read addr 0x12 (misaligned) and addr DEPTH*4 -> oErr and oRdValid in RESP, oDataDataBus=0x0; write to DEPTH*4 leaves bank unchanged.
- Assert iReset during WAIT of a write to 0x20 data 0x12345678 -> no oWrDone, all outputs 0 next cycle, later read of 0x20 returns old value.
- WAIT_STATES=0, back-to-back requests held high -> responses every 2 cycles (N+1, N+3, ...), requests during oBusy ignored.

Source files
------------

// File: rtl/embertrail_dmem_pkg.sv
// Shared types for the Embertrail data-memory responder:
// FSM states, direction constants, bank select and fault read value.
package embertrail_dmem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  typedef enum logic {
    BANK1 = 1'b0,
    BANK2 = 1'b1
  } bank_t;

  localparam logic RW_WRITE = 1'b1;
  localparam logic RW_READ  = 1'b0;

  localparam logic [31:0] ERR_RDATA = 32'h0;

endpackage

// File: rtl/embertrail_dmem_responder_if.sv
// Embertrail data bus between core (master) and responder (slave).
// Requests: address, write data, per-bank RW and enable.
// Responses: read data, rdValid/wrDone/err pulses, busy level.
interface embertrail_dmem_responder_if;

  logic [31:0] iDataAddrBus;
  logic [31:0] iDataWrBus;
  logic        iDataMem1RW;
  logic        iDataMem2RW;
  logic        iData1BusEn;
  logic        iData2BusEn;
  logic [31:0] oDataDataBus;
  logic        oRdValid;
  logic        oWrDone;
  logic        oBusy;
  logic        oErr;

  modport master (
    output iDataAddrBus, iDataWrBus,
    output iDataMem1RW, iDataMem2RW,
    output iData1BusEn, iData2BusEn,
    input  oDataDataBus, oRdValid,
    input  oWrDone, oBusy, oErr
  );

  modport slave (
    input  iDataAddrBus, iDataWrBus,
    input  iDataMem1RW, iDataMem2RW,
    input  iData1BusEn, iData2BusEn,
    output oDataDataBus, oRdValid,
    output oWrDone, oBusy, oErr
  );

endinterface

// File: rtl/embertrail_dmem_bank.sv
// Single-port synchronous SRAM bank, DEPTH x 32, registered read.
// Ports: iClock, iEn (access), iWe (1=write), iAddr, iWrData, oRdData.
module embertrail_dmem_bank #(
  parameter int DEPTH = 256
) (
  input  logic                     iClock,
  input  logic                     iEn,
  input  logic                     iWe,
  input  logic [$clog2(DEPTH)-1:0] iAddr,
  input  logic [31:0]              iWrData,
  output logic [31:0]              oRdData
);

  logic [31:0] mem [DEPTH];

  // oRdData only moves on a read, so it holds the
  // word fetched at request accept until the response.
  always_ff @(posedge iClock) begin
    if (iEn) begin
      if (iWe) begin
        mem[iAddr] <= iWrData;
      end else begin
        oRdData <= mem[iAddr];
      end
    end
  end

endmodule

// File: rtl/embertrail_dmem_responder.sv
// Data-memory responder: two SRAM banks, fixed wait-state timing.
// Ports: iClock, iReset (sync, active high), bus (slave modport).
module embertrail_dmem_responder
  import embertrail_dmem_pkg::*;
#(
  parameter int DEPTH       = 256,
  parameter int WAIT_STATES = 1
) (
  input logic                         iClock,
  input logic                         iReset,
  embertrail_dmem_responder_if.slave  bus
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [2:0] WAIT_LOAD =
    (WAIT_STATES > 0) ? 3'(WAIT_STATES - 1) : 3'd0;

  state_t        state;
  logic [2:0]    waitCnt;
  logic [AW-1:0] capWord;
  logic [31:0]   capData;
  bank_t         capBank;
  logic          capRw;
  logic          capFault;

  logic          reqOne;
  logic          reqBoth;
  bank_t         reqBank;
  logic          reqRw;
  logic [AW-1:0] reqWord;
  logic          reqFault;
  logic          accept;
  logic          commit;
  logic [AW-1:0] bankAddr;

  logic          en1;
  logic          en2;
  logic          we1;
  logic          we2;
  logic [31:0]   rdData1;
  logic [31:0]   rdData2;
  logic [31:0]   rdSel;

  logic          rdValid;
  logic          wrDone;
  logic          busy;
  logic          err;
  logic [31:0]   dataOut;

  assign reqOne  = bus.iData1BusEn ^ bus.iData2BusEn;
  assign reqBoth = bus.iData1BusEn & bus.iData2BusEn;
  assign reqBank = bus.iData2BusEn ? BANK2 : BANK1;
  assign reqRw   = (reqBank == BANK2) ?
                   bus.iDataMem2RW : bus.iDataMem1RW;
  assign reqWord = bus.iDataAddrBus[AW+1:2];

  // Misaligned or any address bit above the bank index set.
  assign reqFault =
    (bus.iDataAddrBus[1:0] != 2'b00) ||
    ((bus.iDataAddrBus >> (AW + 2)) != 32'h0);

  assign accept = (state == IDLE) && reqOne;
  assign commit = (state == RESP) &&
                  (capRw == RW_WRITE) && !capFault;

  // Reads are fetched at accept time from the live address;
  // writes commit in RESP from the captured request.
  assign bankAddr = accept ? reqWord : capWord;

  assign we1 = commit && (capBank == BANK1);
  assign we2 = commit && (capBank == BANK2);

  assign en1 = !iReset && (we1 ||
    (accept && reqBank == BANK1 && reqRw == RW_READ));
  assign en2 = !iReset && (we2 ||
    (accept && reqBank == BANK2 && reqRw == RW_READ));

  assign rdSel = (capBank == BANK2) ? rdData2 : rdData1;

  embertrail_dmem_bank #(
    .DEPTH (DEPTH)
  ) uBank1 (
    .iClock  (iClock),
    .iEn     (en1),
    .iWe     (we1),
    .iAddr   (bankAddr),
    .iWrData (capData),
    .oRdData (rdData1)
  );

  embertrail_dmem_bank #(
    .DEPTH (DEPTH)
  ) uBank2 (
    .iClock  (iClock),
    .iEn     (en2),
    .iWe     (we2),
    .iAddr   (bankAddr),
    .iWrData (capData),
    .oRdData (rdData2)
  );

  always_ff @(posedge iClock) begin
    if (iReset) begin
      state    <= IDLE;
      waitCnt  <= 3'd0;
      capWord  <= '0;
      capData  <= 32'h0;
      capBank  <= BANK1;
      capRw    <= RW_READ;
      capFault <= 1'b0;
      rdValid  <= 1'b0;
      wrDone   <= 1'b0;
      busy     <= 1'b0;
      err      <= 1'b0;
      dataOut  <= 32'h0;
    end else begin
      rdValid <= 1'b0;
      wrDone  <= 1'b0;
      err     <= 1'b0;
      unique case (state)
        IDLE: begin
          if (reqBoth) begin
            err <= 1'b1;
          end else if (reqOne) begin
            capWord  <= reqWord;
            capData  <= bus.iDataWrBus;
            capBank  <= reqBank;
            capRw    <= reqRw;
            capFault <= reqFault;
            busy     <= 1'b1;
            waitCnt  <= WAIT_LOAD;
            state    <= (WAIT_STATES > 0) ? WAIT : RESP;
          end
        end
        WAIT: begin
          if (waitCnt == 3'd0) begin
            state <= RESP;
          end else begin
            waitCnt <= waitCnt - 3'd1;
          end
        end
        RESP: begin
          state <= IDLE;
          busy  <= 1'b0;
          err   <= capFault;
          if (capRw == RW_READ) begin
            rdValid <= 1'b1;
            dataOut <= capFault ? ERR_RDATA : rdSel;
          end else begin
            wrDone <= !capFault;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.oDataDataBus = dataOut;
  assign bus.oRdValid     = rdValid;
  assign bus.oWrDone      = wrDone;
  assign bus.oBusy        = busy;
  assign bus.oErr         = err;

endmodule

// File: tb/tb_embertrail_dmem_responder.sv
// Bench for embertrail_dmem_responder: WAIT_STATES=1 and =0 instances,
// response scoreboard checked on every output pulse.
module tb_embertrail_dmem_responder;

  localparam int DEPTH = 256;

  typedef struct {
    bit          rd;
    bit          wr;
    bit          err;
    logic [31:0] data;
    int          cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   passCnt = 0;
  int   totalCnt = 0;

  exp_t sb1[$];
  exp_t sb0[$];
  exp_t e1;
  exp_t e0;
  logic [31:0] mdl [int];

  embertrail_dmem_responder_if b1();
  embertrail_dmem_responder_if b0();

  embertrail_dmem_responder #(
    .DEPTH       (DEPTH),
    .WAIT_STATES (1)
  ) dut1 (
    .iClock (clk),
    .iReset (rst),
    .bus    (b1)
  );

  embertrail_dmem_responder #(
    .DEPTH       (DEPTH),
    .WAIT_STATES (0)
  ) dut0 (
    .iClock (clk),
    .iReset (rst),
    .bus    (b0)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1);
  end

  always @(negedge clk) begin
    if (b1.oRdValid || b1.oWrDone || b1.oErr) begin
      totalCnt++;
      if (sb1.size() == 0) begin
        $display("FAIL unexpected_pulse1 got rd=%0b wr=%0b err=%0b want none",
                 b1.oRdValid, b1.oWrDone, b1.oErr);
      end else begin
        passCnt++;
        e1 = sb1.pop_front();
        totalCnt++;
        if ({b1.oRdValid, b1.oWrDone, b1.oErr} !== {e1.rd, e1.wr, e1.err})
          $display("FAIL flags1 got %b want %b",
                   {b1.oRdValid, b1.oWrDone, b1.oErr}, {e1.rd, e1.wr, e1.err});
        else passCnt++;
        totalCnt++;
        if (cyc !== e1.cyc)
          $display("FAIL latency1 got cyc %0d want %0d", cyc, e1.cyc);
        else passCnt++;
        if (e1.rd) begin
          totalCnt++;
          if (b1.oDataDataBus !== e1.data)
            $display("FAIL rdata1 got %h want %h", b1.oDataDataBus, e1.data);
          else passCnt++;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (b0.oRdValid || b0.oWrDone || b0.oErr) begin
      totalCnt++;
      if (sb0.size() == 0) begin
        $display("FAIL unexpected_pulse0 got rd=%0b wr=%0b err=%0b want none",
                 b0.oRdValid, b0.oWrDone, b0.oErr);
      end else begin
        passCnt++;
        e0 = sb0.pop_front();
        totalCnt++;
        if ({b0.oRdValid, b0.oWrDone, b0.oErr} !== {e0.rd, e0.wr, e0.err})
          $display("FAIL flags0 got %b want %b",
                   {b0.oRdValid, b0.oWrDone, b0.oErr}, {e0.rd, e0.wr, e0.err});
        else passCnt++;
        totalCnt++;
        if (cyc !== e0.cyc)
          $display("FAIL latency0 got cyc %0d want %0d", cyc, e0.cyc);
        else passCnt++;
        if (e0.rd) begin
          totalCnt++;
          if (b0.oDataDataBus !== e0.data)
            $display("FAIL rdata0 got %h want %h", b0.oDataDataBus, e0.data);
          else passCnt++;
        end
      end
    end
  end

  task automatic drive(int d, bit en1, bit en2, bit rw1, bit rw2,
                       logic [31:0] a, logic [31:0] wd);
    if (d == 1) begin
      b1.iData1BusEn  = en1;
      b1.iData2BusEn  = en2;
      b1.iDataMem1RW  = rw1;
      b1.iDataMem2RW  = rw2;
      b1.iDataAddrBus = a;
      b1.iDataWrBus   = wd;
    end else begin
      b0.iData1BusEn  = en1;
      b0.iData2BusEn  = en2;
      b0.iDataMem1RW  = rw1;
      b0.iDataMem2RW  = rw2;
      b0.iDataAddrBus = a;
      b0.iDataWrBus   = wd;
    end
  endtask

  task automatic drain(int d);
    int k = 0;
    while ((d == 1 ? sb1.size() : sb0.size()) != 0 ||
           (d == 1 ? b1.oBusy : b0.oBusy) !== 1'b0) begin
      @(negedge clk);
      k++;
      if (k > 50) begin
        totalCnt++;
        $display("FAIL drain%0d got busy/pending want idle", d);
        break;
      end
    end
  endtask

  // One request on bank (b2 ? 2 : 1); the other bank's RW is driven
  // opposite so a wrong RW select shows up.
  task automatic issue(int d, bit b2, bit rw, logic [31:0] a,
                       logic [31:0] wd, bit abort);
    exp_t e;
    bit   f;
    int   key;
    drain(d);
    @(negedge clk);
    f = (a[1:0] != 2'b00) || (a >= 32'(DEPTH * 4));
    key = (d * 2 + int'(b2)) * DEPTH + int'((a >> 2) & 32'(DEPTH - 1));
    e.rd   = !rw;
    e.wr   = rw && !f;
    e.err  = f;
    e.cyc  = cyc + 2 + (d == 1 ? 1 : 0);
    e.data = 32'h0;
    if (!rw && !f) e.data = mdl.exists(key) ? mdl[key] : 32'h0;
    if (rw && !f && !abort) mdl[key] = wd;
    drive(d, !b2, b2, b2 ? !rw : rw, b2 ? rw : !rw, a, wd);
    if (!abort) begin
      if (d == 1) sb1.push_back(e);
      else sb0.push_back(e);
    end
    @(negedge clk);
    drive(d, 0, 0, 0, 0, 32'h0, 32'h0);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    totalCnt++;
    if ({b1.oRdValid, b1.oWrDone, b1.oBusy, b1.oErr} !== 4'b0)
      $display("FAIL reset_flags1 got %b want 0000",
               {b1.oRdValid, b1.oWrDone, b1.oBusy, b1.oErr});
    else passCnt++;
    totalCnt++;
    if (b1.oDataDataBus !== 32'h0)
      $display("FAIL reset_data1 got %h want 0", b1.oDataDataBus);
    else passCnt++;
    totalCnt++;
    if ({b0.oRdValid, b0.oWrDone, b0.oBusy, b0.oErr} !== 4'b0)
      $display("FAIL reset_flags0 got %b want 0000",
               {b0.oRdValid, b0.oWrDone, b0.oBusy, b0.oErr});
    else passCnt++;
    totalCnt++;
    if (b0.oDataDataBus !== 32'h0)
      $display("FAIL reset_data0 got %h want 0", b0.oDataDataBus);
    else passCnt++;
    rst = 1'b0;
  endtask

  task automatic test_write();
    issue(1, 0, 1, 32'h10, 32'hDEADBEEF, 0);
    totalCnt++;
    if (b1.oBusy !== 1'b1)
      $display("FAIL busy_accept got %b want 1", b1.oBusy);
    else passCnt++;
    @(negedge clk);
    totalCnt++;
    if (b1.oBusy !== 1'b1)
      $display("FAIL busy_wait got %b want 1", b1.oBusy);
    else passCnt++;
    @(negedge clk);
    totalCnt++;
    if (b1.oBusy !== 1'b0)
      $display("FAIL busy_done got %b want 0", b1.oBusy);
    else passCnt++;
    totalCnt++;
    if (b1.oDataDataBus !== 32'h0)
      $display("FAIL data_after_write got %h want 0", b1.oDataDataBus);
    else passCnt++;
  endtask

  task automatic test_read();
    issue(1, 0, 0, 32'h10, 32'h0, 0);
    issue(1, 1, 1, 32'h10, 32'hCAFE0002, 0);
    issue(1, 1, 0, 32'h10, 32'h0, 0);
    issue(1, 0, 1, 32'h14, 32'h01020304, 0);
    drain(1);
    totalCnt++;
    if (b1.oDataDataBus !== 32'hCAFE0002)
      $display("FAIL data_hold got %h want cafe0002", b1.oDataDataBus);
    else passCnt++;
  endtask

  task automatic test_both();
    exp_t e;
    drain(1);
    @(negedge clk);
    e.rd = 0; e.wr = 0; e.err = 1; e.data = 32'h0;
    e.cyc = cyc + 1;
    sb1.push_back(e);
    drive(1, 1, 1, 0, 0, 32'h10, 32'h0);
    @(negedge clk);
    totalCnt++;
    if (b1.oBusy !== 1'b0)
      $display("FAIL both_busy got %b want 0", b1.oBusy);
    else passCnt++;
    drive(1, 0, 0, 0, 0, 32'h0, 32'h0);
    @(negedge clk);
    totalCnt++;
    if (b1.oBusy !== 1'b0 || b1.oDataDataBus !== 32'hCAFE0002)
      $display("FAIL both_after got busy=%b data=%h want busy=0 data=cafe0002",
               b1.oBusy, b1.oDataDataBus);
    else passCnt++;
  endtask

  task automatic test_fault();
    issue(1, 0, 1, 32'h0, 32'hA5A5A5A5, 0);
    issue(1, 0, 0, 32'h12, 32'h0, 0);
    issue(1, 0, 0, 32'(DEPTH * 4), 32'h0, 0);
    issue(1, 0, 1, 32'(DEPTH * 4), 32'h00000055, 0);
    issue(1, 0, 0, 32'h0, 32'h0, 0);
  endtask

  task automatic test_reset_mid();
    issue(1, 0, 1, 32'h20, 32'h11112222, 0);
    issue(1, 0, 1, 32'h20, 32'h12345678, 1);
    rst = 1'b1;
    @(negedge clk);
    totalCnt++;
    if ({b1.oRdValid, b1.oWrDone, b1.oBusy, b1.oErr} !== 4'b0)
      $display("FAIL abort_flags got %b want 0000",
               {b1.oRdValid, b1.oWrDone, b1.oBusy, b1.oErr});
    else passCnt++;
    totalCnt++;
    if (b1.oDataDataBus !== 32'h0)
      $display("FAIL abort_data got %h want 0", b1.oDataDataBus);
    else passCnt++;
    rst = 1'b0;
    repeat (3) @(negedge clk);
    issue(1, 0, 0, 32'h20, 32'h0, 0);
  endtask

  task automatic test_back_to_back();
    exp_t e;
    int   c;
    issue(0, 0, 1, 32'h0, 32'h0BADF00D, 0);
    drain(0);
    @(negedge clk);
    c = cyc;
    for (int i = 1; i <= 4; i++) begin
      e.rd = 1; e.wr = 0; e.err = 0; e.data = 32'h0BADF00D;
      e.cyc = c + 2 * i;
      sb0.push_back(e);
    end
    drive(0, 1, 0, 0, 1, 32'h0, 32'h0);
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      totalCnt++;
      if (b0.oBusy !== 1'((k % 2) == 1))
        $display("FAIL b2b_busy k=%0d got %b want %b",
                 k, b0.oBusy, 1'((k % 2) == 1));
      else passCnt++;
    end
    drive(0, 0, 0, 0, 0, 32'h0, 32'h0);
  endtask

  initial begin
    drive(1, 0, 0, 0, 0, 32'h0, 32'h0);
    drive(0, 0, 0, 0, 0, 32'h0, 32'h0);
    test_reset();
    test_write();
    test_read();
    test_both();
    test_fault();
    test_reset_mid();
    test_back_to_back();
    drain(0);
    drain(1);
    repeat (4) @(negedge clk);
    totalCnt++;
    if (sb1.size() != 0 || sb0.size() != 0)
      $display("FAIL pending got %0d/%0d want 0/0", sb1.size(), sb0.size());
    else passCnt++;
    $display("%0d/%0d checks passed", passCnt, totalCnt);
    $finish;
  end

endmodule
